ifu_mem_responder: RTL and testbench

//   Memory-side responder for the IFD instruction-fetch read interface. Accepts
//   the ifu_rd_req/ifu_rd_addr request from instr_decode, reads a 2^ADDR_WIDTH x

---
 rtl/ifu_mem_if.sv | 28 ++
 rtl/ifu_mem_responder.sv | 105 ++++++++++
 tb/tb_ifu_mem_responder.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_mem_if.sv
// Instruction-fetch read bus between instr_decode and the memory responder,
// plus the image-load port and the responder's status outputs.
interface ifu_mem_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
);
    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic [DATA_WIDTH-1:0] ifu_rd_data;
    logic                  ifu_rd_vld;
    logic                  ifu_rd_busy;
    logic                  ld_en;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  proto_err;
    logic [CNT_WIDTH-1:0]  fetch_cnt;

    modport master (
        output ifu_rd_req, ifu_rd_addr, ld_en, ld_addr, ld_data,
        input  ifu_rd_data, ifu_rd_vld, ifu_rd_busy, proto_err, fetch_cnt
    );

    modport slave (
        input  ifu_rd_req, ifu_rd_addr, ld_en, ld_addr, ld_data,
        output ifu_rd_data, ifu_rd_vld, ifu_rd_busy, proto_err, fetch_cnt
    );
endinterface

// File: rtl/ifu_mem_responder.sv
// Memory-side responder for IFD instruction fetches: a word store with a fixed
// read latency (1..4), an image-load port, a sticky protocol-error flag and a fetch counter.
module ifu_mem_responder #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 12,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input logic       clk,
    input logic       reset,
    ifu_mem_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int              LAT_W    = 2;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    state_t                state;
    logic [LAT_W-1:0]      lat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  vld_q;
    logic                  busy_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  req_ok;

    // An X/Z request compares as not-equal and is therefore ignored.
    assign req_ok = (bus.ifu_rd_req == 1'b1);

    // The store is deliberately left out of reset so the program image survives it.
    always_ff @(posedge clk) begin
        if (bus.ld_en) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        addr_q  <= bus.ifu_rd_addr;
                        lat_cnt <= LAT_INIT;
                        busy_q  <= 1'b1;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        // Reads happen on the edge entering RESP, so a same-edge load gives the old word.
                        if (READ_LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            state  <= RESP;
                            data_q <= mem[bus.ifu_rd_addr];
                            vld_q  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (req_ok) begin
                        err_q <= 1'b1;
                    end
                    if (lat_cnt == LAT_W'(1)) begin
                        state  <= RESP;
                        data_q <= mem[addr_q];
                        vld_q  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (req_ok) begin
                        err_q <= 1'b1;
                    end
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_rd_data = data_q;
    assign bus.ifu_rd_vld  = vld_q;
    assign bus.ifu_rd_busy = busy_q;
    assign bus.proto_err   = err_q;
    assign bus.fetch_cnt   = cnt_q;

    req_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(bus.ifu_rd_req));
endmodule

// File: tb/tb_ifu_mem_responder.sv
// Self-checking bench for ifu_mem_responder: three instances (latency 1, 3, 4) with
// per-instance scoreboards checked whenever a response pulse appears.
module tb_ifu_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [11:0] ld_data = '0;

    int checks = 0;
    int failures = 0;

    logic [11:0] model [logic [11:0]];
    logic [11:0] exp1 [$];
    logic [11:0] exp3 [$];
    logic [11:0] exp4 [$];
    logic [11:0] e1, e3, e4;

    ifu_mem_if #(.CNT_WIDTH(16)) b1 ();
    ifu_mem_if #(.CNT_WIDTH(16)) b3 ();
    ifu_mem_if #(.CNT_WIDTH(2))  b4 ();

    assign b1.ld_en = ld_en;  assign b1.ld_addr = ld_addr;  assign b1.ld_data = ld_data;
    assign b3.ld_en = ld_en;  assign b3.ld_addr = ld_addr;  assign b3.ld_data = ld_data;
    assign b4.ld_en = ld_en;  assign b4.ld_addr = ld_addr;  assign b4.ld_data = ld_data;

    ifu_mem_responder #(.READ_LATENCY(1), .CNT_WIDTH(16)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    ifu_mem_responder #(.READ_LATENCY(3), .CNT_WIDTH(16)) dut3 (.clk(clk), .reset(reset), .bus(b3));
    ifu_mem_responder #(.READ_LATENCY(4), .CNT_WIDTH(2))  dut4 (.clk(clk), .reset(reset), .bus(b4));

    always #5 clk = ~clk;

    // Response monitors: every vld pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (b1.ifu_rd_vld === 1'b1) begin
            checks++;
            if (exp1.size() == 0) begin
                failures++;
                $display("[TB] FAIL lat1_unexpected_vld: got vld=1 data=%0o, required no response", b1.ifu_rd_data);
            end else begin
                e1 = exp1.pop_front();
                if (b1.ifu_rd_data !== e1) begin
                    failures++;
                    $display("[TB] FAIL lat1_data: got %0o, required %0o", b1.ifu_rd_data, e1);
                end
            end
        end
        if (b3.ifu_rd_vld === 1'b1) begin
            checks++;
            if (exp3.size() == 0) begin
                failures++;
                $display("[TB] FAIL lat3_unexpected_vld: got vld=1 data=%0o, required no response", b3.ifu_rd_data);
            end else begin
                e3 = exp3.pop_front();
                if (b3.ifu_rd_data !== e3) begin
                    failures++;
                    $display("[TB] FAIL lat3_data: got %0o, required %0o", b3.ifu_rd_data, e3);
                end
            end
        end
        if (b4.ifu_rd_vld === 1'b1) begin
            checks++;
            if (exp4.size() == 0) begin
                failures++;
                $display("[TB] FAIL lat4_unexpected_vld: got vld=1 data=%0o, required no response", b4.ifu_rd_data);
            end else begin
                e4 = exp4.pop_front();
                if (b4.ifu_rd_data !== e4) begin
                    failures++;
                    $display("[TB] FAIL lat4_data: got %0o, required %0o", b4.ifu_rd_data, e4);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [11:0] a, input logic [11:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        model[a] = d;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp1.delete(); exp3.delete(); exp4.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({b1.ifu_rd_data, b1.ifu_rd_vld, b1.ifu_rd_busy, b1.proto_err, b1.fetch_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_lat1: got data=%0o vld=%b busy=%b err=%b cnt=%0d, required all 0",
                     b1.ifu_rd_data, b1.ifu_rd_vld, b1.ifu_rd_busy, b1.proto_err, b1.fetch_cnt);
        end
        checks++;
        if ({b3.ifu_rd_data, b3.ifu_rd_vld, b3.ifu_rd_busy, b3.proto_err, b3.fetch_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_lat3: got data=%0o vld=%b busy=%b err=%b cnt=%0d, required all 0",
                     b3.ifu_rd_data, b3.ifu_rd_vld, b3.ifu_rd_busy, b3.proto_err, b3.fetch_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_lat1();
        apply_reset();
        checks++;
        if (b1.ifu_rd_busy !== 1'b0) begin
            failures++; $display("[TB] FAIL t1_busy_before: got %b, required 0", b1.ifu_rd_busy);
        end
        b1.ifu_rd_addr = 12'o200; b1.ifu_rd_req = 1'b1;
        exp1.push_back(model[12'o200]);
        tick();
        b1.ifu_rd_req = 1'b0;
        checks++;
        if ({b1.ifu_rd_vld, b1.ifu_rd_busy} !== 2'b11) begin
            failures++; $display("[TB] FAIL t1_vld_busy: got vld=%b busy=%b, required 1 1", b1.ifu_rd_vld, b1.ifu_rd_busy);
        end
        checks++;
        if (b1.fetch_cnt !== 16'd1) begin
            failures++; $display("[TB] FAIL t1_fetch_cnt: got %0d, required 1", b1.fetch_cnt);
        end
        tick();
        checks++;
        if ({b1.ifu_rd_vld, b1.ifu_rd_busy} !== 2'b00) begin
            failures++; $display("[TB] FAIL t1_after: got vld=%b busy=%b, required 0 0", b1.ifu_rd_vld, b1.ifu_rd_busy);
        end
        checks++;
        if (b1.ifu_rd_data !== 12'o7001) begin
            failures++; $display("[TB] FAIL t1_data_held: got %0o, required 7001", b1.ifu_rd_data);
        end
    endtask

    task automatic test_lat3();
        apply_reset();
        b3.ifu_rd_addr = 12'o201; b3.ifu_rd_req = 1'b1;
        exp3.push_back(model[12'o201]);
        tick();
        b3.ifu_rd_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (b3.ifu_rd_busy !== (i <= 3)) begin
                failures++; $display("[TB] FAIL t2_busy_c%0d: got %b, required %b", i, b3.ifu_rd_busy, (i <= 3));
            end
            checks++;
            if (b3.ifu_rd_vld !== (i == 3)) begin
                failures++; $display("[TB] FAIL t2_vld_c%0d: got %b, required %b", i, b3.ifu_rd_vld, (i == 3));
            end
            tick();
        end
        checks++;
        if (b3.ifu_rd_data !== 12'o1205) begin
            failures++; $display("[TB] FAIL t2_data_held: got %0o, required 1205", b3.ifu_rd_data);
        end
    endtask

    task automatic test_busy_request();
        apply_reset();
        b3.ifu_rd_addr = 12'o201; b3.ifu_rd_req = 1'b1;
        exp3.push_back(model[12'o201]);
        tick();
        b3.ifu_rd_addr = 12'o200;
        tick();
        b3.ifu_rd_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if ({b3.proto_err, b3.fetch_cnt} !== {1'b1, 16'd1}) begin
            failures++; $display("[TB] FAIL t3_err_cnt_wait: got err=%b cnt=%0d, required 1 1", b3.proto_err, b3.fetch_cnt);
        end
        checks++;
        if (exp3.size() != 0) begin
            failures++; $display("[TB] FAIL t3_drain: got %0d pending responses, required 0", exp3.size());
        end
        // A request in the RESP cycle of the latency-1 instance is also a busy request.
        b1.ifu_rd_addr = 12'o200; b1.ifu_rd_req = 1'b1;
        exp1.push_back(model[12'o200]);
        tick();
        b1.ifu_rd_addr = 12'o201;
        tick();
        b1.ifu_rd_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({b1.proto_err, b1.fetch_cnt} !== {1'b1, 16'd1}) begin
            failures++; $display("[TB] FAIL t3_err_cnt_resp: got err=%b cnt=%0d, required 1 1", b1.proto_err, b1.fetch_cnt);
        end
        checks++;
        if (b3.proto_err !== 1'b1) begin
            failures++; $display("[TB] FAIL t3_err_sticky: got %b, required 1", b3.proto_err);
        end
    endtask

    task automatic test_load_collision();
        apply_reset();
        b1.ifu_rd_addr = 12'o300; b1.ifu_rd_req = 1'b1;
        ld_en = 1'b1; ld_addr = 12'o300; ld_data = 12'o7402;
        exp1.push_back(12'o5200);
        tick();
        b1.ifu_rd_req = 1'b0;
        tick();
        ld_en = 1'b0;
        model[12'o300] = 12'o7402;
        tick();
        b1.ifu_rd_req = 1'b1;
        exp1.push_back(12'o7402);
        tick();
        b1.ifu_rd_req = 1'b0;
        // A load one cycle after acceptance on the latency-3 instance must be seen.
        b3.ifu_rd_addr = 12'o400; b3.ifu_rd_req = 1'b1;
        exp3.push_back(12'o0777);
        tick();
        b3.ifu_rd_req = 1'b0;
        load_word(12'o400, 12'o0777);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (exp1.size() + exp3.size() != 0) begin
            failures++; $display("[TB] FAIL t4_drain: got %0d pending responses, required 0", exp1.size() + exp3.size());
        end
        checks++;
        if (b1.proto_err !== 1'b0) begin
            failures++; $display("[TB] FAIL t4_no_err: got %b, required 0", b1.proto_err);
        end
    endtask

    task automatic test_reset_mid();
        int vld_seen;
        apply_reset();
        b4.ifu_rd_addr = 12'o200; b4.ifu_rd_req = 1'b1;
        tick();
        b4.ifu_rd_req = 1'b0;
        tick();
        checks++;
        if ({b4.ifu_rd_busy, b4.fetch_cnt} !== 3'b101) begin
            failures++; $display("[TB] FAIL t5_in_wait: got busy=%b cnt=%0d, required 1 1", b4.ifu_rd_busy, b4.fetch_cnt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({b4.ifu_rd_data, b4.ifu_rd_vld, b4.ifu_rd_busy, b4.proto_err, b4.fetch_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL t5_cleared: got data=%0o vld=%b busy=%b err=%b cnt=%0d, required all 0",
                     b4.ifu_rd_data, b4.ifu_rd_vld, b4.ifu_rd_busy, b4.proto_err, b4.fetch_cnt);
        end
        vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (b4.ifu_rd_vld === 1'b1) vld_seen++;
            tick();
        end
        checks++;
        if (vld_seen != 0) begin
            failures++; $display("[TB] FAIL t5_no_vld: got %0d pulses, required 0", vld_seen);
        end
        b4.ifu_rd_req = 1'b1;
        exp4.push_back(12'o7001);
        tick();
        b4.ifu_rd_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (exp4.size() != 0) begin
            failures++; $display("[TB] FAIL t5_refetch: got %0d pending responses, required 0", exp4.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] addrs [3];
        addrs[0] = 12'o7776; addrs[1] = 12'o7777; addrs[2] = 12'o0000;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            b1.ifu_rd_addr = addrs[i]; b1.ifu_rd_req = 1'b1;
            exp1.push_back(model[addrs[i]]);
            tick();
            b1.ifu_rd_req = 1'b0;
            tick();
        end
        tick();
        checks++;
        if ({b1.proto_err, b1.fetch_cnt} !== {1'b0, 16'd3}) begin
            failures++; $display("[TB] FAIL t6_err_cnt: got err=%b cnt=%0d, required 0 3", b1.proto_err, b1.fetch_cnt);
        end
        checks++;
        if (exp1.size() != 0) begin
            failures++; $display("[TB] FAIL t6_drain: got %0d pending responses, required 0", exp1.size());
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            b4.ifu_rd_addr = (i % 2 == 0) ? 12'o7777 : 12'o0000;
            b4.ifu_rd_req = 1'b1;
            exp4.push_back(model[b4.ifu_rd_addr]);
            tick();
            b4.ifu_rd_req = 1'b0;
            for (int j = 0; j < 4; j++) tick();
            want = (i >= 3) ? 2'd3 : 2'(i);
            checks++;
            if (b4.fetch_cnt !== want) begin
                failures++; $display("[TB] FAIL t6_sat_%0d: got %0d, required %0d", i, b4.fetch_cnt, want);
            end
        end
        checks++;
        if (exp4.size() != 0 || b4.proto_err !== 1'b0) begin
            failures++; $display("[TB] FAIL t6_sat_drain: got pending=%0d err=%b, required 0 0", exp4.size(), b4.proto_err);
        end
    endtask

    initial begin
        b1.ifu_rd_req = 1'b0; b1.ifu_rd_addr = '0;
        b3.ifu_rd_req = 1'b0; b3.ifu_rd_addr = '0;
        b4.ifu_rd_req = 1'b0; b4.ifu_rd_addr = '0;
        test_reset();
        load_word(12'o0200, 12'o7001);
        load_word(12'o0201, 12'o1205);
        load_word(12'o0300, 12'o5200);
        load_word(12'o0400, 12'o2345);
        load_word(12'o7776, 12'o6001);
        load_word(12'o7777, 12'o5377);
        load_word(12'o0000, 12'o7300);
        test_lat1();
        test_lat3();
        test_busy_request();
        test_load_collision();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
